bellek_yanitlayici: RTL and testbench

Memory-side responder for the `islemci` single-port memory bus. Holds a word-addressed RAM image at `BELLEK_ADRES` and serves instruction fetches, loads and stores. Adds a small MMIO window with an output FIFO, a free-running cycle counter and a sticky error register. Sits directly opposite the processor in the top level and in simulation benches.

---
 rtl/bellek_yanitlayici_pkg.sv | 10 +
 rtl/bellek_yanitlayici_cikis.sv | 37 +++
 rtl/bellek_yanitlayici.sv | 70 +++++++
 tb/tb_bellek_yanitlayici.sv | 132 +++++++++++++
 4 files changed

// File: rtl/bellek_yanitlayici_pkg.sv
// bellek_paket: shared MMIO offsets, invalid-read pattern and HATA bit positions
package bellek_paket;
  localparam logic [3:0] CIKIS_OFS = 4'h0;
  localparam logic [3:0] SAYAC_OFS = 4'h4;
  localparam logic [3:0] HATA_OFS = 4'h8;
  localparam logic [3:0] HATA_ADRES_OFS = 4'hC;
  localparam logic [31:0] GECERSIZ_VERI = 32'hDEAD_BEEF;
  localparam int ARALIK_DISI_BIT = 0;
  localparam int TASMA_BIT = 1;
endpackage

// File: rtl/bellek_yanitlayici_cikis.sv
// cikis_fifo: output word FIFO; a push while full is accepted only if a pop frees a slot that edge
module cikis_fifo #(
  parameter int DERINLIK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        it_gecerli,
  input  logic [31:0] it_veri,
  input  logic        cek,
  output logic [31:0] bas_veri,
  output logic        bos,
  output logic        dolu
);
  localparam int AW = $clog2(DERINLIK);
  logic [31:0] mem [DERINLIK];
  logic [AW-1:0] yaz_ptr, oku_ptr;
  logic [AW:0] sayi;
  logic yaz, oku;
  assign bos = sayi == '0;
  assign dolu = sayi == (AW+1)'(DERINLIK);
  assign oku = cek && !bos;
  assign yaz = it_gecerli && (!dolu || oku);
  assign bas_veri = mem[oku_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
      sayi <= '0;
      mem[0] <= '0;
    end else begin
      if (yaz) mem[yaz_ptr] <= it_veri;
      if (yaz) yaz_ptr <= yaz_ptr + AW'(1);
      if (oku) oku_ptr <= oku_ptr + AW'(1);
      sayi <= sayi + (AW+1)'(yaz) - (AW+1)'(oku);
    end
  end
endmodule

// File: rtl/bellek_yanitlayici.sv
// bellek_yanitlayici: RAM plus MMIO (output FIFO, cycle counter, sticky errors) on the islemci bus
module bellek_yanitlayici
  import bellek_paket::*;
#(
  parameter logic [31:0] BELLEK_ADRES = 32'h8000_0000,
  parameter int BELLEK_KELIME = 1024,
  parameter logic [31:0] MMIO_ADRES = 32'h2000_0000,
  parameter int FIFO_DERINLIK = 4,
  parameter string BASLANGIC_DOSYA = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bellek_adres,
  output logic [31:0] bellek_oku_veri,
  input  logic [31:0] bellek_yaz_veri,
  input  logic        bellek_yaz,
  output logic [31:0] cikis_veri,
  output logic        cikis_gecerli,
  input  logic        cikis_hazir,
  output logic        hata
);
  localparam int IW = $clog2(BELLEK_KELIME);
  localparam logic [31:0] RAM_BOYUT = 32'(4 * BELLEK_KELIME);
  logic [31:0] ram [BELLEK_KELIME];
  logic [31:0] fark, sayac, hata_adres;
  logic [1:0] hata_bit, ofs;
  logic ram_sec, mmio_sec, gecersiz, cikis_sec, hata_sec, it, bos, dolu;
  assign fark = bellek_adres - BELLEK_ADRES;
  assign ram_sec = fark < RAM_BOYUT;
  assign mmio_sec = bellek_adres[31:4] == MMIO_ADRES[31:4];
  assign gecersiz = !ram_sec && !mmio_sec;
  assign ofs = bellek_adres[3:2];
  assign cikis_sec = mmio_sec && ofs == CIKIS_OFS[3:2];
  assign hata_sec = mmio_sec && ofs == HATA_OFS[3:2];
  assign it = bellek_yaz && cikis_sec;
  assign cikis_gecerli = !bos;
  assign hata = |hata_bit;
  cikis_fifo #(.DERINLIK(FIFO_DERINLIK)) u_fifo (
    .clk(clk), .rst(rst), .it_gecerli(it), .it_veri(bellek_yaz_veri),
    .cek(cikis_hazir), .bas_veri(cikis_veri), .bos(bos), .dolu(dolu)
  );
  always_comb begin
    bellek_oku_veri = ram_sec ? ram[fark[IW+1:2]] :
                      !mmio_sec ? GECERSIZ_VERI :
                      ofs == CIKIS_OFS[3:2] ? {30'b0, bos, dolu} :
                      ofs == SAYAC_OFS[3:2] ? sayac :
                      ofs == HATA_OFS[3:2] ? {30'b0, hata_bit} :
                      hata_adres;
  end
  always_ff @(posedge clk) begin
    if (!rst && bellek_yaz && ram_sec) ram[fark[IW+1:2]] <= bellek_yaz_veri;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sayac <= '0;
      hata_bit <= '0;
      hata_adres <= '0;
    end else begin
      sayac <= sayac + 32'd1;
      if (bellek_yaz && hata_sec) begin
        hata_bit <= '0;
        hata_adres <= '0;
      end else begin
        if (gecersiz) hata_bit[ARALIK_DISI_BIT] <= 1'b1;
        if (gecersiz && !hata_bit[ARALIK_DISI_BIT]) hata_adres <= bellek_adres;
        if (it && dolu && !cikis_hazir) hata_bit[TASMA_BIT] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bellek_yanitlayici.sv
// tb_bellek_yanitlayici: directed checks of RAM, MMIO decode, FIFO, counter, errors and reset
module tb_bellek_yanitlayici;
  localparam logic [31:0] BOS = 32'h8000_0000;
  localparam logic [31:0] CIKIS = 32'h2000_0000;
  localparam logic [31:0] SAYAC = 32'h2000_0004;
  localparam logic [31:0] HATA = 32'h2000_0008;
  localparam logic [31:0] HATA_ADRES = 32'h2000_000C;
  logic clk = 0, rst = 1, bellek_yaz = 0, cikis_hazir = 0;
  logic [31:0] bellek_adres = BOS, bellek_yaz_veri = 0;
  logic [31:0] bellek_oku_veri, cikis_veri;
  logic cikis_gecerli, hata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  bellek_yanitlayici dut (
    .clk(clk), .rst(rst), .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri),
    .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz), .cikis_veri(cikis_veri),
    .cikis_gecerli(cikis_gecerli), .cikis_hazir(cikis_hazir), .hata(hata)
  );
  task automatic kontrol(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic adim();
    @(posedge clk);
    #1;
  endtask
  task automatic yaz(input logic [31:0] a, input logic [31:0] d);
    bellek_adres = a;
    bellek_yaz_veri = d;
    bellek_yaz = 1;
    adim();
    bellek_yaz = 0;
    bellek_adres = BOS;
  endtask
  task automatic oku(input logic [31:0] a, input logic [31:0] e, input string tag);
    bellek_adres = a;
    #1;
    kontrol(tag, bellek_oku_veri, e);
    adim();
    bellek_adres = BOS;
  endtask
  initial begin
    adim();
    adim();
    kontrol("reset_gecerli", {31'b0, cikis_gecerli}, 0);
    kontrol("reset_veri", cikis_veri, 0);
    kontrol("reset_hata", {31'b0, hata}, 0);
    rst = 0;
    bellek_adres = SAYAC;
    #1;
    kontrol("sayac_ilk", bellek_oku_veri, 0);
    repeat (100) adim();
    kontrol("sayac_100", bellek_oku_veri, 100);
    bellek_adres = BOS;
    yaz(32'h8000_0000, 32'h0000_0013);
    yaz(32'h8000_0010, 32'h1234_5678);
    oku(32'h8000_0010, 32'h1234_5678, "ram_oku");
    oku(32'h8000_0013, 32'h1234_5678, "ram_alt_bit");
    oku(32'h8000_0000, 32'h0000_0013, "ram_kelime0");
    yaz(32'h8000_0FFC, 32'hA5A5_5A5A);
    oku(32'h8000_0FFC, 32'hA5A5_5A5A, "ram_son");
    kontrol("hata_yok", {31'b0, hata}, 0);
    oku(32'h0000_0100, 32'hDEAD_BEEF, "gecersiz_oku");
    kontrol("hata_set", {31'b0, hata}, 1);
    oku(HATA, 1, "hata_reg");
    oku(HATA_ADRES, 32'h0000_0100, "hata_adres");
    oku(32'h9000_0000, 32'hDEAD_BEEF, "gecersiz2");
    oku(HATA_ADRES, 32'h0000_0100, "hata_adres_sabit");
    yaz(HATA, 0);
    oku(HATA, 0, "hata_temiz");
    oku(HATA_ADRES, 0, "hata_adres_temiz");
    kontrol("hata_pin_temiz", {31'b0, hata}, 0);
    oku(32'h8000_1000, 32'hDEAD_BEEF, "ram_ust_sinir");
    oku(HATA_ADRES, 32'h8000_1000, "hata_adres_sinir");
    yaz(HATA, 0);
    for (int i = 1; i <= 5; i++) yaz(CIKIS, i);
    oku(CIKIS, 1, "fifo_dolu");
    oku(HATA, 2, "tasma");
    cikis_hazir = 1;
    for (int i = 1; i <= 4; i++) begin
      kontrol("fifo_sira", cikis_veri, i);
      adim();
    end
    cikis_hazir = 0;
    kontrol("fifo_bos", {31'b0, cikis_gecerli}, 0);
    oku(CIKIS, 2, "fifo_bos_durum");
    yaz(HATA, 0);
    for (int i = 5; i <= 8; i++) yaz(CIKIS, i);
    cikis_hazir = 1;
    yaz(CIKIS, 9);
    cikis_hazir = 0;
    kontrol("es_zaman_bas", cikis_veri, 6);
    oku(CIKIS, 1, "es_zaman_dolu");
    oku(HATA, 0, "es_zaman_tasma_yok");
    cikis_hazir = 1;
    for (int i = 6; i <= 9; i++) begin
      kontrol("es_zaman_sira", cikis_veri, i);
      adim();
    end
    cikis_hazir = 0;
    kontrol("es_zaman_bos", {31'b0, cikis_gecerli}, 0);
    yaz(32'h8000_0020, 32'h0000_0055);
    yaz(CIKIS, 32'hA);
    yaz(CIKIS, 32'hB);
    yaz(CIKIS, 32'hC);
    oku(32'h0000_0100, 32'hDEAD_BEEF, "gecersiz3");
    kontrol("once_gecerli", {31'b0, cikis_gecerli}, 1);
    kontrol("once_hata", {31'b0, hata}, 1);
    rst = 1;
    bellek_adres = 32'h8000_0020;
    bellek_yaz_veri = 32'hFFFF_FFFF;
    bellek_yaz = 1;
    #1;
    kontrol("reset_oku", bellek_oku_veri, 32'h0000_0055);
    adim();
    rst = 0;
    bellek_yaz = 0;
    bellek_adres = SAYAC;
    #1;
    kontrol("ara_sayac", bellek_oku_veri, 0);
    kontrol("ara_gecerli", {31'b0, cikis_gecerli}, 0);
    kontrol("ara_veri", cikis_veri, 0);
    kontrol("ara_hata", {31'b0, hata}, 0);
    adim();
    oku(32'h8000_0020, 32'h0000_0055, "ara_ram");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
